// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared types and constants for the sprite layer
package sprite_pkg;

    // Per-channel position record, used for both the pending and the active copy.
    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       en;
    } spr_pos_t;

    // DrawX/DrawY/blank to red/green/blue, in pixel clocks.
    localparam int PIPE_LAT = 3;

    // Palette index that never produces a visible pixel.
    localparam int TRANSPARENT_IDX = 0;

endpackage

// File: rtl/sprite_palette.sv
// rtl/sprite_palette.sv - combinational palette lookup for the winning sprite pixel
//
// Ports:
//   idx_i   palette index of the winning pixel (never the transparent index here)
//   chan_i  channel number of the winning sprite, tints the blue component
//   red_o, green_o, blue_o  4-bit colour components
//
// Mapping: red = idx[3:0], green = idx[7:4], blue = idx[3:0] ^ channel.
// Narrower indices are zero-extended to 8 bits before the lookup.
module sprite_palette #(
    parameter int IDX_W = 8
) (
    input  logic [IDX_W-1:0] idx_i,
    input  logic [2:0]       chan_i,
    output logic [3:0]       red_o,
    output logic [3:0]       green_o,
    output logic [3:0]       blue_o
);

    logic [7:0] ix;

    always_comb begin
        ix      = 8'(idx_i);
        red_o   = ix[3:0];
        green_o = ix[7:4];
        blue_o  = ix[3:0] ^ {1'b0, chan_i};
    end

endmodule

// File: rtl/sprite_layer.sv
// rtl/sprite_layer.sv - multi-channel sprite overlay with frame-synchronous position update
//
// Optional feature macro: SPRITE_FLASH_EN (per-channel white flash counters).
//
// Ports:
//   vga_clk, Reset          pixel clock, synchronous active-high reset
//   DrawX, DrawY, blank     current pixel coordinate and visible-region flag
//   frame_start             one-cycle pulse at the first blanking cycle of a frame
//   pos_wr, pos_id, pos_x, pos_y, pos_en   pending position/enable write port
//   rom_addr                per-channel sprite ROM address, channel k at [k*ROM_AW +: ROM_AW]
//   rom_q                   per-channel ROM data, one cycle after rom_addr
//   red, green, blue        registered output colour, 3 cycles after DrawX/DrawY/blank
//   flash_trig              per-channel flash request (only acted on with SPRITE_FLASH_EN)
module sprite_layer
    import sprite_pkg::*;
#(
    parameter int N_SPR        = 4,
    parameter int SPR_W        = 50,
    parameter int SPR_H        = 40,
    parameter int ROM_AW       = 11,
    parameter int IDX_W        = 8,
    parameter int FLASH_FRAMES = 8,
    localparam int ID_W        = (N_SPR > 1) ? $clog2(N_SPR) : 1
) (
    input  logic                      vga_clk,
    input  logic                      Reset,
    input  logic [9:0]                DrawX,
    input  logic [9:0]                DrawY,
    input  logic                      blank,
    input  logic                      frame_start,
    input  logic                      pos_wr,
    input  logic [ID_W-1:0]           pos_id,
    input  logic [9:0]                pos_x,
    input  logic [9:0]                pos_y,
    input  logic                      pos_en,
    output logic [N_SPR*ROM_AW-1:0]   rom_addr,
    input  logic [N_SPR*IDX_W-1:0]    rom_q,
    output logic [3:0]                red,
    output logic [3:0]                green,
    output logic [3:0]                blue,
    input  logic [N_SPR-1:0]          flash_trig
);

    // ------------------------------------------------------------------
    // Position registers: software writes pending, frame_start copies all
    // channels to active so a sprite never moves partway down the screen.
    // ------------------------------------------------------------------
    spr_pos_t pend_q [N_SPR];
    spr_pos_t act_q  [N_SPR];

    always_ff @(posedge vga_clk) begin
        if (Reset) begin
            for (int k = 0; k < N_SPR; k++) begin
                pend_q[k] <= '0;
                act_q[k]  <= '0;
            end
        end else begin
            // Active takes the value pending held before this cycle's write,
            // so a write coinciding with frame_start shows one frame later.
            if (frame_start) begin
                for (int k = 0; k < N_SPR; k++) begin
                    act_q[k] <= pend_q[k];
                end
            end
            if (pos_wr && (int'(pos_id) < N_SPR)) begin
                pend_q[pos_id] <= '{x: pos_x, y: pos_y, en: pos_en};
            end
        end
    end

    // ------------------------------------------------------------------
    // Flash counters (optional)
    // ------------------------------------------------------------------
`ifdef SPRITE_FLASH_EN
    logic [3:0] flash_q [N_SPR];

    always_ff @(posedge vga_clk) begin
        if (Reset) begin
            for (int k = 0; k < N_SPR; k++) begin
                flash_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < N_SPR; k++) begin
                // A trigger wins over a same-cycle frame_start decrement.
                if (flash_trig[k]) begin
                    flash_q[k] <= 4'(FLASH_FRAMES);
                end else if (frame_start && (flash_q[k] != 4'd0)) begin
                    flash_q[k] <= flash_q[k] - 4'd1;
                end
            end
        end
    end
`else
    logic unused_flash_trig;
    localparam int unused_flash_frames = FLASH_FRAMES;
    assign unused_flash_trig = ^flash_trig;
`endif

    // ------------------------------------------------------------------
    // Stage 0: hit test and ROM address per channel
    // ------------------------------------------------------------------
    logic [10:0]               dx [N_SPR];
    logic [10:0]               dy [N_SPR];
    logic [N_SPR-1:0]          hit_d;
    logic [N_SPR*ROM_AW-1:0]   rom_addr_d;

    always_comb begin
        hit_d      = '0;
        rom_addr_d = '0;
        for (int k = 0; k < N_SPR; k++) begin
            // 11-bit unsigned differences: a coordinate left of or above the
            // sprite wraps to a large value and fails the range compare.
            dx[k] = {1'b0, DrawX} - {1'b0, act_q[k].x};
            dy[k] = {1'b0, DrawY} - {1'b0, act_q[k].y};
            if (act_q[k].en && (dx[k] < 11'(SPR_W)) && (dy[k] < 11'(SPR_H))) begin
                hit_d[k] = 1'b1;
                rom_addr_d[k*ROM_AW +: ROM_AW] =
                    ROM_AW'(dx[k]) + ROM_AW'(dy[k]) * ROM_AW'(SPR_W);
            end
        end
    end

    logic [N_SPR*ROM_AW-1:0] rom_addr_q;
    logic [N_SPR-1:0]        hit0_q;
    logic                    blank0_q;
    logic [N_SPR-1:0]        hit1_q;
    logic                    blank1_q;

    // Stage 1 only delays hit/blank: the ROM's own output register holds the
    // index during this cycle, and stage 2 reads rom_q directly.
    always_ff @(posedge vga_clk) begin
        if (Reset) begin
            rom_addr_q <= '0;
            hit0_q     <= '0;
            blank0_q   <= 1'b0;
            hit1_q     <= '0;
            blank1_q   <= 1'b0;
        end else begin
            rom_addr_q <= rom_addr_d;
            hit0_q     <= hit_d;
            blank0_q   <= blank;
            hit1_q     <= hit0_q;
            blank1_q   <= blank0_q;
        end
    end

    assign rom_addr = rom_addr_q;

    // ------------------------------------------------------------------
    // Stage 2: priority winner, palette, output register
    // ------------------------------------------------------------------
    logic             win_found;
    logic [IDX_W-1:0] win_idx;
    logic [2:0]       win_ch;
    logic             win_flash;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_ch    = '0;
        win_flash = 1'b0;
        for (int k = 0; k < N_SPR; k++) begin
            if (!win_found && hit1_q[k] &&
                (rom_q[k*IDX_W +: IDX_W] != IDX_W'(TRANSPARENT_IDX))) begin
                win_found = 1'b1;
                win_idx   = rom_q[k*IDX_W +: IDX_W];
                win_ch    = 3'(k);
`ifdef SPRITE_FLASH_EN
                // Odd implies nonzero.
                win_flash = flash_q[k][0];
`endif
            end
        end
    end

    logic [3:0] pal_r, pal_g, pal_b;

    sprite_palette #(
        .IDX_W (IDX_W)
    ) u_palette (
        .idx_i   (win_idx),
        .chan_i  (win_ch),
        .red_o   (pal_r),
        .green_o (pal_g),
        .blue_o  (pal_b)
    );

    logic [11:0] rgb_d;
    logic [11:0] rgb_q;

    always_comb begin
        rgb_d = '0;
        if (win_found && blank1_q) begin
            rgb_d = win_flash ? 12'hFFF : {pal_r, pal_g, pal_b};
        end
    end

    always_ff @(posedge vga_clk) begin
        if (Reset) begin
            rgb_q <= '0;
        end else begin
            rgb_q <= rgb_d;
        end
    end

    assign red   = rgb_q[11:8];
    assign green = rgb_q[7:4];
    assign blue  = rgb_q[3:0];

endmodule

// File: tb/tb_sprite_layer.sv
// tb/tb_sprite_layer.sv - directed self-checking bench for sprite_layer
module tb_sprite_layer;
    import sprite_pkg::*;

    localparam int N   = 4;
    localparam int AW  = 11;
    localparam int IW  = 8;

    logic            vga_clk = 1'b0;
    logic            Reset = 1'b1;
    logic [9:0]      DrawX = '0, DrawY = '0;
    logic            blank = 1'b0;
    logic            frame_start = 1'b0;
    logic            pos_wr = 1'b0;
    logic [1:0]      pos_id = '0;
    logic [9:0]      pos_x = '0, pos_y = '0;
    logic            pos_en = 1'b0;
    logic [N*AW-1:0] rom_addr;
    logic [N*IW-1:0] rom_q = '0;
    logic [3:0]      red, green, blue;
    logic [N-1:0]    flash_trig = '0;
    logic [N-1:0]    zero_mask = '0;

    int checks = 0;
    int errors = 0;

    always #5 vga_clk = ~vga_clk;

    sprite_layer dut (
        .vga_clk(vga_clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY),
        .blank(blank), .frame_start(frame_start), .pos_wr(pos_wr),
        .pos_id(pos_id), .pos_x(pos_x), .pos_y(pos_y), .pos_en(pos_en),
        .rom_addr(rom_addr), .rom_q(rom_q), .red(red), .green(green),
        .blue(blue), .flash_trig(flash_trig)
    );

    // Synchronous ROM model: content depends on address and channel.
    function automatic logic [7:0] rom_idx(input logic [10:0] a, input int ch);
        return a[7:0] + 8'(17 * (ch + 1));
    endfunction

    always @(posedge vga_clk) begin
        for (int k = 0; k < N; k++) begin
            rom_q[k*IW +: IW] <= zero_mask[k] ? 8'd0 : rom_idx(rom_addr[k*AW +: AW], k);
        end
    end

    // Expected colour of channel ch showing ROM address a.
    function automatic logic [11:0] col(input logic [10:0] a, input int ch);
        logic [7:0] i;
        i = rom_idx(a, ch);
        return {i[3:0], i[7:4], i[3:0] ^ 4'(ch)};
    endfunction

    function automatic logic [11:0] rgb();
        return {red, green, blue};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic wr(input int id, input int x, input int y, input logic en, input logic fs);
        pos_id = 2'(id); pos_x = 10'(x); pos_y = 10'(y); pos_en = en;
        pos_wr = 1'b1; frame_start = fs;
        step();
        pos_wr = 1'b0; frame_start = 1'b0;
    endtask

    task automatic fs_pulse();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    // Hold one pixel for the full pipeline latency, then compare the colour.
    task automatic pix(input string name, input int x, input int y, input logic [11:0] exp);
        DrawX = 10'(x); DrawY = 10'(y); blank = 1'b1;
        repeat (PIPE_LAT) step();
        chk(name, 32'(rgb()), 32'(exp));
    endtask

    typedef struct {
        int          x;
        int          y;
        logic        b;
        logic [10:0] addr0;
        logic [11:0] rgb;
    } vec_t;

    vec_t v [10];

    initial begin
        // Channel 0 at (100,80), only channel enabled.
        v[0] = '{100,  80, 1'b1,   11'd0, col(11'd0, 0)};
        v[1] = '{149, 119, 1'b1, 11'd1999, col(11'd1999, 0)};
        v[2] = '{150, 119, 1'b1,   11'd0, 12'h000};
        v[3] = '{ 99,  80, 1'b1,   11'd0, 12'h000};
        v[4] = '{100,  79, 1'b1,   11'd0, 12'h000};
        v[5] = '{100, 120, 1'b1,   11'd0, 12'h000};
        v[6] = '{110,  85, 1'b1, 11'd260, col(11'd260, 0)};
        v[7] = '{110,  85, 1'b0, 11'd260, 12'h000};
        v[8] = '{  0,   0, 1'b1,   11'd0, 12'h000};
        v[9] = '{125, 100, 1'b1, 11'd1025, col(11'd1025, 0)};

        // Reset state
        step(); step();
        chk("reset_rom_addr", 32'(rom_addr), 32'd0);
        chk("reset_rgb", 32'(rgb()), 32'd0);
        Reset = 1'b0;
        step();

        wr(0, 100, 80, 1'b1, 1'b0);
        pix("pending_not_active", 100, 80, 12'h000);
        fs_pulse();

        // Streamed vectors: one pixel per cycle, colour checked 3 cycles later.
        for (int i = 0; i < 10; i++) begin
            DrawX = 10'(v[i].x); DrawY = 10'(v[i].y); blank = v[i].b;
            step();
            chk($sformatf("vec%0d_addr0", i), 32'(rom_addr[AW-1:0]), 32'(v[i].addr0));
            if (i >= 2) chk($sformatf("vec%0d_rgb", i - 2), 32'(rgb()), 32'(v[i-2].rgb));
        end
        DrawX = '0; DrawY = '0; blank = 1'b0;
        step();
        chk("vec8_rgb", 32'(rgb()), 32'(v[8].rgb));
        step();
        chk("vec9_rgb", 32'(rgb()), 32'(v[9].rgb));

        // Mid-frame move is deferred to the next frame_start.
        wr(0, 300, 80, 1'b1, 1'b0);
        pix("midframe_old_pos", 100, 80, col(11'd0, 0));
        pix("midframe_new_pos", 300, 80, 12'h000);
        fs_pulse();
        pix("nextframe_new_pos", 300, 80, col(11'd0, 0));
        pix("nextframe_old_pos", 100, 80, 12'h000);

        // Write coinciding with frame_start lands one frame later.
        wr(0, 100, 80, 1'b1, 1'b1);
        pix("coincide_still_old", 300, 80, col(11'd0, 0));
        pix("coincide_not_new", 100, 80, 12'h000);
        fs_pulse();
        pix("coincide_applied", 100, 80, col(11'd0, 0));

        // Overlap priority
        wr(1, 100, 80, 1'b1, 1'b0);
        fs_pulse();
        pix("overlap_ch0_wins", 110, 85, col(11'd260, 0));
        zero_mask = 4'b0001;
        pix("overlap_ch0_transparent", 110, 85, col(11'd260, 1));
        zero_mask = 4'b0011;
        pix("overlap_both_transparent", 110, 85, 12'h000);
        zero_mask = 4'b0000;

        // Reset mid-line
        pix("pre_reset_pixel", 100, 80, col(11'd0, 0));
        Reset = 1'b1;
        wr(0, 200, 80, 1'b1, 1'b1);
        flash_trig = '0;
        chk("midreset_rgb", 32'(rgb()), 32'd0);
        chk("midreset_rom_addr", 32'(rom_addr), 32'd0);
        Reset = 1'b0;
        pix("after_reset_cleared", 100, 80, 12'h000);
        pix("after_reset_no_pos", 200, 80, 12'h000);
        wr(0, 100, 80, 1'b1, 1'b0);
        pix("after_reset_pending_only", 100, 80, 12'h000);
        fs_pulse();
        pix("after_reset_restored", 100, 80, col(11'd0, 0));

        // Flash: count 8 after trigger, white on odd counts.
        flash_trig = 4'b0001;
        step();
        flash_trig = '0;
        pix("flash_cnt8", 100, 80, col(11'd0, 0));
        for (int f = 1; f <= 8; f++) begin
            logic [11:0] e;
            fs_pulse();
            e = col(11'd0, 0);
`ifdef SPRITE_FLASH_EN
            if (((8 - f) % 2) == 1) e = 12'hFFF;
`endif
            pix($sformatf("flash_frame%0d", f), 100, 80, e);
        end
        // Trigger with frame_start: loads 8 without decrementing.
        flash_trig = 4'b0001;
        frame_start = 1'b1;
        step();
        flash_trig = '0;
        frame_start = 1'b0;
        pix("flash_trig_with_fs", 100, 80, col(11'd0, 0));
        fs_pulse();
`ifdef SPRITE_FLASH_EN
        pix("flash_after_trig_fs", 100, 80, 12'hFFF);
`else
        pix("flash_after_trig_fs", 100, 80, col(11'd0, 0));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sprite_layer.md
SPRITE_LAYER -- requirements
Module: sprite_layer

Interface
REQ-001 Parameter N_SPR, default 4, number of sprite channels (1..8).
REQ-002 Parameter SPR_W, default 50, sprite width in pixels; SPR_H, default 40, sprite height in pixels.
REQ-003 Parameter ROM_AW, default 11, sprite ROM address width (SPR_W*SPR_H <= 2**ROM_AW).
REQ-004 Parameter IDX_W, default 8, palette index width; index 0 = transparent.
REQ-005 vga_clk  in  1  pixel clock; all state on posedge.
REQ-006 Reset  in  1  synchronous, active-high reset.
REQ-007 DrawX, DrawY  in  10 each  current pixel coordinate.
REQ-008 blank  in  1  1 = visible region, 0 = blanking.
REQ-009 frame_start  in  1  one-cycle pulse at the first blanking cycle of each frame.
REQ-010 pos_wr  in  1  position/enable write strobe; pos_id  in  clog2(N_SPR)  target channel; pos_x, pos_y  in  10 each  new top-left corner; pos_en  in  1  channel visible.
REQ-011 rom_addr  out  N_SPR*ROM_AW  per-channel ROM address, channel k at bits [k*ROM_AW +: ROM_AW].
REQ-012 rom_q  in  N_SPR*IDX_W  per-channel ROM data, valid exactly one cycle after rom_addr.
REQ-013 red, green, blue  out  4 each  registered pixel colour.
REQ-014 flash_trig  in  N_SPR  per-channel flash request (used only with the macro of REQ-029).

Function
REQ-015 Each channel holds pending (x, y, en) and active (x, y, en) registers; pos_wr updates pending[pos_id] in one cycle; pos_id >= N_SPR is ignored.
REQ-016 On frame_start, all active registers load from pending, so on-screen positions never change mid-frame.
REQ-017 pos_wr and frame_start in the same cycle: active loads the pre-write pending value; the write appears on the following frame.
REQ-018 Stage 0 (cycle t): channel k hits when active en=1, DrawX-x < SPR_W and DrawY-y < SPR_H as unsigned 11-bit differences, so coordinates left/above the sprite never hit.
REQ-019 Stage 0 registers rom_addr_k = (DrawX-x) + (DrawY-y)*SPR_W for hits and 0 otherwise, together with hit vector and blank.
REQ-020 Stage 1 (t+1): the rom_q index and the delayed hit/blank are registered.
REQ-021 Stage 2 (t+2): winner = lowest-numbered channel with hit=1 and index != 0; the palette gives RGB, and red/green/blue are registered at t+3.
REQ-022 No winner, or delayed blank=0: red/green/blue = 0.
REQ-023 Total latency DrawX/DrawY/blank to RGB = 3 cycles, with one pixel per cycle and no stalls.

Reset
REQ-024 Reset clears pending and active registers: x=0, y=0, en=0.
REQ-025 Reset clears all pipeline registers; rom_addr=0 and red/green/blue=0 in the cycle after Reset is sampled high.
REQ-026 Reset overrides pos_wr, frame_start and flash_trig in the same cycle.
REQ-027 Reset mid-frame: outputs are 0 until valid pixels traverse the pipeline again; no sprite shows until a pos_wr followed by a frame_start.

Configuration
REQ-028 Parameter FLASH_FRAMES, default 8, flash duration in frames.
REQ-029 With SPRITE_FLASH_EN defined, flash_trig[k]=1 loads channel k's 4-bit flash counter with FLASH_FRAMES, and frame_start decrements it while nonzero; a trigger and frame_start in the same cycle load without decrementing.
REQ-030 While counter_k is nonzero and odd, channel k's winning pixels output 4'hF on all colours; Reset clears the counters.
REQ-031 Without SPRITE_FLASH_EN, flash_trig is ignored, no counters exist, and the palette colour is always output.

Structure
REQ-032 Package sprite_pkg holds: a typedef for the channel position record (x, y, en); localparam PIPE_LAT=3; the transparent-index constant 0.
REQ-033 A single sub-module sprite_palette (index and channel in, 4-bit RGB out, combinational) is instantiated once after winner selection.

Verification
REQ-034 Reset, pos_wr id0 x=100 y=80 en=1, frame_start, then drive DrawX=100 DrawY=80 -> rom_addr0=0 at t+1; RGB = palette(rom_q0) at t+3.
REQ-035 DrawX=149 DrawY=119 -> rom_addr0=1999; DrawX=150 or DrawX=99 -> no hit, RGB=0.
REQ-036 Channels 0 and 1 overlap, both indices nonzero -> channel 0 colour; channel 0 index 0 -> channel 1 colour.
REQ-037 pos_wr id0 x=300 mid-frame -> pixels still drawn at x=100 until the next frame_start; pos_wr coinciding with frame_start -> applied one frame later.
REQ-038 blank=0 at a hit pixel -> RGB=0 exactly 3 cycles later; Reset asserted mid-line -> RGB=0 the next cycle.
REQ-039 With SPRITE_FLASH_EN, flash_trig[0] then 8 frame_starts -> channel 0 white on counts 7,5,3,1 and normal colour otherwise; without the macro -> never white.
